// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: widths, defaults, fetch FSM states.
// No logic, no latency.
// No flow control.
package mips_pkg;

    localparam int          INSTR_W      = 32;
    localparam int          IM_AW_DEF    = 7;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } fetch_state_t;

    // A PC is fetchable when word aligned and inside the 2^aw-word memory.
    // The compare is a full 32-bit one, so a wrapped pc+4 lands out of range.
    function automatic logic pc_legal(input logic [31:0] pc, input int aw);
        logic [31:0] w_limit;
        w_limit  = 32'd4 << aw;
        pc_legal = (pc[1:0] == 2'b00) && (pc < w_limit);
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Fetch-stage bus: pipeline controls in, instruction memory port, IF/ID outputs.
// Pure wiring, no latency.
// stall/flush/redirect are the only backpressure; memory answers in the same cycle.
interface ifetch_if #(
    parameter int IM_AW = mips_pkg::IM_AW_DEF
);
    import mips_pkg::*;

    logic               stall;
    logic               flush;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic [IM_AW-1:0]   im_addr;
    logic [INSTR_W-1:0] im_data;
    logic [31:0]        pc;
    logic [INSTR_W-1:0] ifid_instr;
    logic [31:0]        ifid_pc4;
    logic               ifid_valid;
    logic               fault;

    // Fetch stage side
    modport master (
        input  stall, flush, redirect, redirect_pc, im_data,
        output im_addr, pc, ifid_instr, ifid_pc4, ifid_valid, fault
    );

    // Pipeline / memory side
    modport slave (
        output stall, flush, redirect, redirect_pc, im_data,
        input  im_addr, pc, ifid_instr, ifid_pc4, ifid_valid, fault
    );

endinterface

// File: rtl/ifetch_ifid_reg.sv
// IF/ID pipeline register holding instruction, PC+4 and a valid bit.
// One edge from load to output.
// Clear beats load; with neither asserted everything holds (stall).
module ifid_reg
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [31:0]        i_pc4,
    output logic [INSTR_W-1:0] o_instr,
    output logic [31:0]        o_pc4,
    output logic               o_valid
);

    logic [INSTR_W-1:0] r_instr;
    logic [31:0]        r_pc4;
    logic               r_valid;

    // Clear only drops valid so the stale payload stays visible for debug.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= '0;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: PC, instruction memory address, IF/ID capture, fault latch.
// im_addr combinational from pc; instruction lands in IF/ID one edge later.
// stall holds pc and IF/ID; redirect overrides stall; a fault freezes everything.
module ifetch
    import mips_pkg::*;
#(
    parameter int          IM_AW    = IM_AW_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic     clk,
    input  logic     rst_n,
    ifetch_if.master bus
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_fault;

    logic [31:0]  w_pc4;
    logic         w_legal;
    logic         w_load;
    logic         w_clear;

    assign w_pc4   = r_pc + 32'd4;
    assign w_legal = pc_legal(r_pc, IM_AW);

    // IF/ID controls: illegal pc, redirect and flush all invalidate; advance loads.
    always_comb begin
        w_load  = 1'b0;
        w_clear = 1'b0;
        case (r_state)
            RUN: begin
                if (!w_legal || bus.redirect || bus.flush) begin
                    w_clear = 1'b1;
                end else if (!bus.stall) begin
                    w_load = 1'b1;
                end
            end
            FAULT:   w_clear = 1'b1;
            default: ;
        endcase
    end

    // Fetch FSM with PC and sticky fault; BOOT spends one cycle before fetching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                BOOT: r_state <= RUN;
                RUN: begin
                    if (!w_legal) begin
                        r_state <= FAULT;
                        r_fault <= 1'b1;
                    end else if (bus.redirect) begin
                        r_pc <= bus.redirect_pc;
                    end else if (!bus.stall) begin
                        // Covers both plain advance and flush without stall.
                        r_pc <= w_pc4;
                    end
                end
                FAULT:   r_fault <= 1'b1;
                default: r_state <= FAULT;
            endcase
        end
    end

    ifid_reg u_ifid_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_instr (bus.im_data),
        .i_pc4   (w_pc4),
        .o_instr (bus.ifid_instr),
        .o_pc4   (bus.ifid_pc4),
        .o_valid (bus.ifid_valid)
    );

    assign bus.im_addr = r_pc[IM_AW+1:2];
    assign bus.pc      = r_pc;
    assign bus.fault   = r_fault;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: reset, fetch, stall, redirect, flush, fault, range edge.
// Outputs sampled 1 time unit after each rising edge.
// Controls driven right after the sample point.
module tb_ifetch;

    localparam int AW = 7;

    logic clk;
    logic rst_n;
    logic [31:0] mem [0:(1<<AW)-1];
    int n_chk;
    int n_err;

    ifetch_if #(.IM_AW(AW)) bus ();

    ifetch #(.IM_AW(AW), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.im_data = mem[bus.im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrl(input logic s, input logic f, input logic r, input logic [31:0] rp);
        bus.stall       = s;
        bus.flush       = f;
        bus.redirect    = r;
        bus.redirect_pc = rp;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] pc,
                            input logic [31:0] instr, input logic [31:0] pc4, input logic v);
        chk({tag, ".pc"},    bus.pc,         pc);
        chk({tag, ".instr"}, bus.ifid_instr, instr);
        chk({tag, ".pc4"},   bus.ifid_pc4,   pc4);
        chk({tag, ".valid"}, {31'd0, bus.ifid_valid}, {31'd0, v});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        chk_ifid("rst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("rst.fault", {31'd0, bus.fault}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA000_0000 + i;
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
        ctrl(0, 0, 0, 32'h0);
        rst_n = 1'b1;
        #2;

        // Reset release and streaming fetch
        do_reset();
        tick();
        chk_ifid("boot", 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        chk_ifid("f0", 32'h4, 32'h11, 32'h4, 1'b1);
        tick();
        chk_ifid("f1", 32'h8, 32'h22, 32'h8, 1'b1);

        // Stall three edges at pc=8
        ctrl(1, 0, 0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_ifid($sformatf("stall%0d", k), 32'h8, 32'h22, 32'h8, 1'b1);
        end
        ctrl(0, 0, 0, 32'h0);
        tick();
        chk_ifid("resume", 32'hC, 32'h33, 32'hC, 1'b1);

        // Redirect wins over stall
        ctrl(1, 0, 1, 32'h40);
        tick();
        chk_ifid("redir", 32'h40, 32'h33, 32'hC, 1'b0);
        ctrl(0, 0, 0, 32'h0);
        tick();
        chk_ifid("redir_cap", 32'h44, 32'hA000_0010, 32'h44, 1'b1);

        // Flush alone at pc=0x10
        ctrl(0, 0, 1, 32'h10);
        tick();
        chk("to10.pc", bus.pc, 32'h10);
        ctrl(0, 1, 0, 32'h0);
        tick();
        chk_ifid("flush", 32'h14, 32'hA000_0010, 32'h44, 1'b0);
        ctrl(0, 0, 0, 32'h0);
        tick();
        chk_ifid("postflush", 32'h18, 32'hA000_0005, 32'h18, 1'b1);

        // Misaligned redirect faults one cycle later and sticks
        ctrl(0, 0, 1, 32'h42);
        tick();
        chk_ifid("mis", 32'h42, 32'hA000_0005, 32'h18, 1'b0);
        chk("mis.fault0", {31'd0, bus.fault}, 32'd0);
        ctrl(0, 0, 0, 32'h0);
        tick();
        chk("mis.fault1", {31'd0, bus.fault}, 32'd1);
        chk("mis.pc", bus.pc, 32'h42);
        chk("mis.valid", {31'd0, bus.ifid_valid}, 32'd0);
        ctrl(0, 1, 1, 32'h0);
        tick();
        tick();
        chk("absorb.pc", bus.pc, 32'h42);
        chk("absorb.fault", {31'd0, bus.fault}, 32'd1);
        ctrl(0, 0, 0, 32'h0);
        do_reset();

        // Run to the top of memory, then fall off the end
        tick();
        ctrl(0, 0, 1, 32'h1F8);
        tick();
        chk("top.pc", bus.pc, 32'h1F8);
        ctrl(0, 0, 0, 32'h0);
        tick();
        chk_ifid("top126", 32'h1FC, 32'hA000_007E, 32'h1FC, 1'b1);
        chk("top.addr", {25'd0, bus.im_addr}, 32'd127);
        tick();
        chk_ifid("top127", 32'h200, 32'hA000_007F, 32'h200, 1'b1);
        chk("top.fault0", {31'd0, bus.fault}, 32'd0);
        tick();
        chk_ifid("oor", 32'h200, 32'hA000_007F, 32'h200, 1'b0);
        chk("oor.fault", {31'd0, bus.fault}, 32'd1);

        // Asynchronous reset in the middle of RUN
        do_reset();
        tick();
        tick();
        tick();
        chk_ifid("pre_arst", 32'h8, 32'h22, 32'h8, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_ifid("arst", 32'h0, 32'h0, 32'h0, 1'b0);
        chk("arst.fault", {31'd0, bus.fault}, 32'd0);
        #5;
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
